f_pc: RTL and testbench
=======================

# f_pc

Fetch-stage program counter for the five-stage MIPS pipeline. Holds PC_F, computes the next PC from the sequential path or a redirect resolved in D (branch, j/jal, jr), honours hazard stalls, and drives the instruction memory address and fetch-clear. Illegal fetch addresses (misaligned or outside the instruction-memory window) halt fetch and record the faulting PC.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset; base of the instruction-memory window
- IM_WORDS, 4096, instruction-memory depth in words; the legal window is [RESET_PC, RESET_PC + 4*IM_WORDS)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit freeze; PC holds
- npc_op  in  2  from D: 00 sequential, 01 branch, 10 j/jal, 11 jr
- branch_taken  in  1  D-stage comparator result; used only when npc_op=01
- pc_d  in  32  PC of the instruction in D
- imm16  in  16  branch offset from the instruction in D
- instr_index  in  26  j/jal target field
- jr_target  in  32  forwarded rs value for jr
- pc_f  out  32  current fetch PC, to IM and the F/D register
- clear_f  out  1  to IM clear; forces instr_F to 0 (nop)
- fault  out  1  sticky illegal-fetch flag
- fault_pc  out  32  first illegal PC
- fetch_cnt  out  32  count of accepted PC advances

## Operation
- Reset values (asynchronous on reset_n=0): pc_f=RESET_PC, clear_f=0, fault=0, fault_pc=0, fetch_cnt=0, state RUN.
- npc is combinational:
  - branch taken: pc_d + 4 + (sign_extend(imm16) << 2)
  - j/jal: {pc_d[31:28], instr_index, 2'b00}
  - jr: jr_target
  - otherwise: pc_f + 4
- npc_op=01 with branch_taken=0 selects pc_f + 4.
- All additions are 32-bit modulo with no carry-out.
- Delay-slot semantics: the redirect applies to the fetch after the slot instruction. The slot instruction is already in F when the redirect is accepted, and it is never squashed.
- An address is illegal if addr[1:0] != 0, addr < RESET_PC, or addr >= RESET_PC + 4*IM_WORDS.
- State RUN, on a clock edge:
  - stall=1: hold pc_f and fetch_cnt. Redirect inputs are ignored, because D is frozen too and presents them again.
  - stall=0: pc_f <= npc and fetch_cnt += 1 (32-bit wrap).
  - If the loaded npc is illegal: move to HALT, set fault=1, fault_pc <= npc.
- State HALT:
  - pc_f, fault_pc and fetch_cnt hold.
  - stall and npc_op are ignored.
  - Only reset_n leaves HALT.
- clear_f = 1 in HALT, else 0. It is registered with the state, so it rises in the same cycle pc_f first shows the illegal value. IM therefore never indexes out of range with clear_f=0.
- Priority: reset_n > HALT > stall > redirect > sequential.

## Timing
- Redirect latency: a redirect presented in cycle n with stall=0 appears on pc_f in cycle n+1.
- A stall held for k cycles delays that by exactly k cycles.
- fetch_cnt equals the number of edges with state RUN and stall=0 since reset.
- fault, fault_pc, clear_f and pc_f all update on the same edge.
- Reset assertion mid-operation, including in HALT, clears everything immediately, without waiting for a clock edge.
- The first edge after reset_n rises is a normal RUN edge.
- fault_pc records only the first illegal PC; later values cannot occur because HALT freezes.

## Test plan
- Reset, then 3 free edges with npc_op=00 -> pc_f goes 3000, 3004, 3008, 300C; fetch_cnt=3; clear_f=0.
- At pc_f=3008, stall=1 for 2 edges, then release -> pc_f stays 3008 for 2 cycles, then 300C; fetch_cnt advances only on unstalled edges.
- Branch redirects, each with npc_op=01, branch_taken=1, pc_d=3004:
  - imm16=0003 -> next pc_f=3014.
  - imm16=FFFF -> next pc_f=3004.
  - branch_taken=0 -> next pc_f=pc_f+4.
- Jump redirects:
  - npc_op=10, pc_d=3010, instr_index=0000C10 -> pc_f=3040.
  - npc_op=11, jr_target=3100 -> pc_f=3100.
  - Either redirect held under stall=1 -> pc_f unchanged until stall drops.
- Illegal jr targets:
  - jr_target=3002 -> pc_f=3002, fault=1, fault_pc=3002, clear_f=1 on the same edge. Further edges with any inputs leave all outputs frozen.
  - Repeat from reset with jr_target=7000 -> same behaviour, fault_pc=7000.
- In HALT, pulse reset_n low between clock edges -> all outputs return to reset values asynchronously; the next free edges give 3004, 3008.

Source files
------------

// File: rtl/f_pc.sv
// Fetch-stage program counter: selects the next PC from the sequential path or
// a D-stage redirect, honours stalls, and halts on the first illegal fetch address.
module f_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_f,
    output logic        clear_f,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] IM_END = RESET_PC + 32'(IM_WORDS << 2);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        clear_q;
    logic        fault_q;
    logic [31:0] fault_pc_q;
    logic [31:0] cnt_q;

    logic [31:0] npc_d;
    logic [31:0] branch_off;
    logic        npc_illegal;

    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

    // Redirects come from the D-stage instruction, so targets are relative to pc_d.
    always_comb begin
        npc_d = pc_q + 32'd4;
        unique case (npc_op)
            2'b01:   if (branch_taken) npc_d = pc_d + 32'd4 + branch_off;
            2'b10:   npc_d = {pc_d[31:28], instr_index, 2'b00};
            2'b11:   npc_d = jr_target;
            default: npc_d = pc_q + 32'd4;
        endcase
    end

    assign npc_illegal = (npc_d[1:0] != 2'b00) || (npc_d < RESET_PC) || (npc_d >= IM_END);

    // clear_f is registered alongside the state so it rises with the illegal pc_f.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            clear_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
            cnt_q      <= 32'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!stall) begin
                        pc_q  <= npc_d;
                        cnt_q <= cnt_q + 32'd1;
                        if (npc_illegal) begin
                            state_q    <= HALT;
                            clear_q    <= 1'b1;
                            fault_q    <= 1'b1;
                            fault_pc_q <= npc_d;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= HALT;
                    clear_q <= 1'b1;
                end
            endcase
        end
    end

    assign pc_f      = pc_q;
    assign clear_f   = clear_q;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_f_pc.sv
// Directed self-checking bench for f_pc: sequential fetch, stalls, redirects,
// illegal-address halt and asynchronous reset out of HALT.
module tb_f_pc;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic [1:0]  npc_op;
    logic        branch_taken;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] pc_f;
    logic        clear_f;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_cnt;

    int compareCount = 0;
    int failCount    = 0;

    f_pc dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .npc_op       (npc_op),
        .branch_taken (branch_taken),
        .pc_d         (pc_d),
        .imm16        (imm16),
        .instr_index  (instr_index),
        .jr_target    (jr_target),
        .pc_f         (pc_f),
        .clear_f      (clear_f),
        .fault        (fault),
        .fault_pc     (fault_pc),
        .fetch_cnt    (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s failed", tag);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] expPc, input logic expClear,
                            input logic expFault, input logic [31:0] expFaultPc,
                            input logic [31:0] expCnt);
        checkOutput({tag, ".pc_f"}, pc_f, expPc);
        checkOutput({tag, ".clear_f"}, {31'd0, clear_f}, {31'd0, expClear});
        checkOutput({tag, ".fault"}, {31'd0, fault}, {31'd0, expFault});
        checkOutput({tag, ".fault_pc"}, fault_pc, expFaultPc);
        checkOutput({tag, ".fetch_cnt"}, fetch_cnt, expCnt);
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] op, input logic tk,
                                 input logic [31:0] pd, input logic [15:0] im,
                                 input logic [25:0] idx, input logic [31:0] jt);
        stall = st; npc_op = op; branch_taken = tk; pc_d = pd;
        imm16 = im; instr_index = idx; jr_target = jt;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset low between edges and confirm the clear is asynchronous.
    task automatic asyncReset(input string tag);
        #2 reset_n = 1'b0;
        #2 checkAll(tag, 32'h3000, 1'b0, 1'b0, 32'h0, 32'd0);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; npc_op = 2'b00; branch_taken = 1'b0;
        pc_d = 32'h0; imm16 = 16'h0; instr_index = 26'h0; jr_target = 32'h0;
        #12;
        checkAll("reset", 32'h3000, 1'b0, 1'b0, 32'h0, 32'd0);
        #1 reset_n = 1'b1;

        applyStimulus(0, 2'b00, 0, 32'h0, 16'h0, 26'h0, 32'h0);
        checkAll("seq1", 32'h3004, 1'b0, 1'b0, 32'h0, 32'd1);
        applyStimulus(0, 2'b00, 0, 32'h0, 16'h0, 26'h0, 32'h0);
        checkAll("seq2", 32'h3008, 1'b0, 1'b0, 32'h0, 32'd2);

        applyStimulus(1, 2'b00, 0, 32'h0, 16'h0, 26'h0, 32'h0);
        checkAll("stall1", 32'h3008, 1'b0, 1'b0, 32'h0, 32'd2);
        applyStimulus(1, 2'b00, 0, 32'h0, 16'h0, 26'h0, 32'h0);
        checkAll("stall2", 32'h3008, 1'b0, 1'b0, 32'h0, 32'd2);
        applyStimulus(0, 2'b00, 0, 32'h0, 16'h0, 26'h0, 32'h0);
        checkAll("unstall", 32'h300C, 1'b0, 1'b0, 32'h0, 32'd3);

        applyStimulus(0, 2'b01, 1, 32'h3004, 16'h0003, 26'h0, 32'h0);
        checkAll("brFwd", 32'h3014, 1'b0, 1'b0, 32'h0, 32'd4);
        applyStimulus(0, 2'b01, 1, 32'h3004, 16'hFFFF, 26'h0, 32'h0);
        checkAll("brBack", 32'h3004, 1'b0, 1'b0, 32'h0, 32'd5);
        applyStimulus(0, 2'b01, 0, 32'h3004, 16'h0003, 26'h0, 32'h0);
        checkAll("brNotTaken", 32'h3008, 1'b0, 1'b0, 32'h0, 32'd6);

        applyStimulus(0, 2'b10, 0, 32'h3010, 16'h0, 26'h0000C10, 32'h0);
        checkAll("jump", 32'h3040, 1'b0, 1'b0, 32'h0, 32'd7);
        applyStimulus(0, 2'b11, 0, 32'h0, 16'h0, 26'h0, 32'h3100);
        checkAll("jr", 32'h3100, 1'b0, 1'b0, 32'h0, 32'd8);

        applyStimulus(1, 2'b11, 0, 32'h0, 16'h0, 26'h0, 32'h3200);
        checkAll("jrStall1", 32'h3100, 1'b0, 1'b0, 32'h0, 32'd8);
        applyStimulus(1, 2'b11, 0, 32'h0, 16'h0, 26'h0, 32'h3200);
        checkAll("jrStall2", 32'h3100, 1'b0, 1'b0, 32'h0, 32'd8);
        applyStimulus(0, 2'b11, 0, 32'h0, 16'h0, 26'h0, 32'h3200);
        checkAll("jrRelease", 32'h3200, 1'b0, 1'b0, 32'h0, 32'd9);

        applyStimulus(0, 2'b11, 0, 32'h0, 16'h0, 26'h0, 32'h3002);
        checkAll("misaligned", 32'h3002, 1'b1, 1'b1, 32'h3002, 32'd10);
        applyStimulus(0, 2'b00, 0, 32'h0, 16'h0, 26'h0, 32'h0);
        checkAll("haltSeq", 32'h3002, 1'b1, 1'b1, 32'h3002, 32'd10);
        applyStimulus(0, 2'b11, 0, 32'h0, 16'h0, 26'h0, 32'h3400);
        checkAll("haltJr", 32'h3002, 1'b1, 1'b1, 32'h3002, 32'd10);
        applyStimulus(1, 2'b10, 0, 32'h3010, 16'h0, 26'h0000C10, 32'h0);
        checkAll("haltStall", 32'h3002, 1'b1, 1'b1, 32'h3002, 32'd10);

        asyncReset("asyncRst1");
        applyStimulus(0, 2'b00, 0, 32'h0, 16'h0, 26'h0, 32'h0);
        checkAll("postRst1", 32'h3004, 1'b0, 1'b0, 32'h0, 32'd1);
        applyStimulus(0, 2'b00, 0, 32'h0, 16'h0, 26'h0, 32'h0);
        checkAll("postRst2", 32'h3008, 1'b0, 1'b0, 32'h0, 32'd2);

        applyStimulus(0, 2'b11, 0, 32'h0, 16'h0, 26'h0, 32'h6FFC);
        checkAll("lastLegal", 32'h6FFC, 1'b0, 1'b0, 32'h0, 32'd3);
        applyStimulus(0, 2'b11, 0, 32'h0, 16'h0, 26'h0, 32'h7000);
        checkAll("aboveWindow", 32'h7000, 1'b1, 1'b1, 32'h7000, 32'd4);
        applyStimulus(0, 2'b01, 1, 32'h3004, 16'h0003, 26'h0, 32'h0);
        checkAll("haltBranch", 32'h7000, 1'b1, 1'b1, 32'h7000, 32'd4);

        asyncReset("asyncRst2");
        applyStimulus(0, 2'b11, 0, 32'h0, 16'h0, 26'h0, 32'h2FFC);
        checkAll("belowWindow", 32'h2FFC, 1'b1, 1'b1, 32'h2FFC, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
